dram_io_responder: RTL and testbench

- Chip-side counterpart of the DRAM write/read IO controller: it receives what the controller sends and answers its reads.
- On the write side it deserialises the per-chip write data and the shared write address, then commits rows into a per-chip row store.
- On the read side it deserialises the per-chip read address, selects an 8-bit slice and returns it serially on DRAM16_data under PC_data control.
- Used as a synthesizable loopback target and as the bench model behind the 16-core write/read controller.

---
 rtl/dram_io_responder.sv | 176 +++++++++++++++++
 tb/tb_dram_io_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dram_io_responder.sv
// dram_io_responder: chip-side model of the DRAM write/read IO path.
// Deserialises write address/data into a per-chip row store and answers
// serial read requests with an 8-bit slice shifted out MSB first.

// One chip lane: write/read shift registers, row store, read buffer, PISO.
module dram_io_lane #(
  parameter int ROWS     = 64,
  parameter int ROW_BITS = 64,
  parameter int AW       = 6
) (
  input  logic          clk_100m,
  input  logic          rst_n,
  input  logic          d_in,
  input  logic          d_shift,
  input  logic          d_clr,
  input  logic          r_ad,
  input  logic          r_shift,
  input  logic          r_clr,
  input  logic [AW-1:0] waddr,
  input  logic          wr_rise,
  input  logic          rd_rise,
  input  logic          de_add3,
  input  logic          piso_act,
  input  logic          piso_sr,
  output logic          dout
);
  localparam logic [AW:0] ROWS_L = (AW+1)'(ROWS);

  logic [ROW_BITS-1:0] wsr;
  logic [7:0]          rsr;
  logic [7:0]          obuf;
  logic [7:0]          piso;
  logic [ROW_BITS-1:0] mem [ROWS];

  logic [AW-1:0]       rrow;
  logic [2:0]          rslice;
  logic                wr_ok;
  logic                rd_ok;
  logic [ROW_BITS-1:0] row_data;
  logic [7:0]          slice_data;

  assign rrow   = rsr[AW-1:0];
  assign rslice = {de_add3, rsr[7:6]};
  assign wr_ok  = wr_rise && ({1'b0, waddr} < ROWS_L);
  assign rd_ok  = {1'b0, rrow} < ROWS_L;

  // Write-first: a read of the row being committed this cycle sees the new data.
  always_comb begin
    row_data = mem[rrow];
    if (wr_ok && (waddr == rrow)) row_data = wsr;
    slice_data = row_data[{rslice, 3'b000} +: 8];
  end

  // Write data deserialiser; clear has priority over a coincident shift.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n)       wsr <= '0;
    else if (d_clr)   wsr <= '0;
    else if (d_shift) wsr <= {wsr[ROW_BITS-2:0], d_in};
  end

  // Read address deserialiser; clear has priority over a coincident shift.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n)       rsr <= '0;
    else if (r_clr)   rsr <= '0;
    else if (r_shift) rsr <= {rsr[6:0], r_ad};
  end

  // Row store: deliberately unreset so contents survive a reset.
  always_ff @(posedge clk_100m) begin
    if (wr_ok) mem[waddr] <= wsr;
  end

  // Read buffer latches the selected slice; out-of-range rows return zero.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n)       obuf <= '0;
    else if (rd_rise) obuf <= rd_ok ? slice_data : 8'h00;
  end

  // PISO: load from the read buffer or shift left on each active PC_data edge.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n)        piso <= '0;
    else if (piso_act) piso <= piso_sr ? {piso[6:0], 1'b0} : obuf;
  end

  assign dout = piso[7];
endmodule

// Top: strobe edge detection, shared write address, commit pulses, lane array.
module dram_io_responder #(
  parameter int N_CHIP   = 16,
  parameter int ROWS     = 64,
  parameter int ROW_BITS = 64
) (
  input  logic              clk_100m,
  input  logic              rst_n,
  input  logic              ADD_IN,
  input  logic              ADD_VALID_IN,
  input  logic [1:0]        PC_D_IN,
  input  logic [N_CHIP-1:0] D_IN,
  input  logic              DATA_VALID_IN,
  input  logic              WRI_EN,
  input  logic [N_CHIP-1:0] R_AD,
  input  logic [1:0]        PC_R_AD,
  input  logic              DE_ADD3,
  input  logic              RD_EN,
  input  logic [2:0]        PC_data,
  output logic [N_CHIP-1:0] DRAM16_data,
  output logic              WR_CMT,
  output logic              RD_CMT
);
  localparam int AW = 6;

  // Strobe order: {PC_data[0], RD_EN, WRI_EN, PC_R_AD[0], PC_D_IN[0]}
  logic [4:0]    strb;
  logic [4:0]    strb_q;
  logic [4:0]    rise;
  logic          armed;
  logic          pd_fall;
  logic          piso_act;
  logic [AW-1:0] waddr;

  assign strb    = {PC_data[0], RD_EN, WRI_EN, PC_R_AD[0], PC_D_IN[0]};
  // armed masks the first post-reset cycle so levels held through reset
  // release are absorbed into the history rather than seen as edges.
  assign rise    = strb & ~strb_q & {5{armed}};
  assign pd_fall = ~PC_data[0] & strb_q[4] & armed;
  assign piso_act = PC_data[2] ? pd_fall : rise[4];

  // Edge history for every strobe.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      strb_q <= '0;
      armed  <= 1'b0;
    end else begin
      strb_q <= strb;
      armed  <= 1'b1;
    end
  end

  // Shared write address, keeps the last 6 bits shifted in.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n)            waddr <= '0;
    else if (ADD_VALID_IN) waddr <= {waddr[AW-2:0], ADD_IN};
  end

  // Commit pulses: one cycle after the edge that did the work.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      WR_CMT <= 1'b0;
      RD_CMT <= 1'b0;
    end else begin
      WR_CMT <= rise[2];
      RD_CMT <= rise[3];
    end
  end

  for (genvar k = 0; k < N_CHIP; k++) begin : g_lane
    dram_io_lane #(.ROWS(ROWS), .ROW_BITS(ROW_BITS), .AW(AW)) u_lane (
      .clk_100m (clk_100m),
      .rst_n    (rst_n),
      .d_in     (D_IN[k]),
      .d_shift  (rise[0] & DATA_VALID_IN),
      .d_clr    (~PC_D_IN[1]),
      .r_ad     (R_AD[k]),
      .r_shift  (rise[1]),
      .r_clr    (~PC_R_AD[1]),
      .waddr    (waddr),
      .wr_rise  (rise[2]),
      .rd_rise  (rise[3]),
      .de_add3  (DE_ADD3),
      .piso_act (piso_act),
      .piso_sr  (PC_data[1]),
      .dout     (DRAM16_data[k])
    );
  end
endmodule

// File: tb/tb_dram_io_responder.sv
// Directed bench for dram_io_responder: loopback, slice/row select, clear
// priority, write-first collision, inverted PISO clock, reset mid-read.
module tb_dram_io_responder;
  localparam int N = 16;

  logic          clk_100m = 1'b0;
  logic          rst_n;
  logic          ADD_IN, ADD_VALID_IN, DATA_VALID_IN, WRI_EN, DE_ADD3, RD_EN;
  logic [1:0]    PC_D_IN, PC_R_AD;
  logic [N-1:0]  D_IN, R_AD;
  logic [2:0]    PC_data;
  logic [N-1:0]  DRAM16_data;
  logic          WR_CMT, RD_CMT;

  int n_cmp = 0;
  int n_err = 0;

  logic [N-1:0][63:0] wdat;
  logic [N-1:0][7:0]  radr, got, exp_b;

  dram_io_responder #(.N_CHIP(N), .ROWS(64), .ROW_BITS(64)) dut (
    .clk_100m(clk_100m), .rst_n(rst_n), .ADD_IN(ADD_IN), .ADD_VALID_IN(ADD_VALID_IN),
    .PC_D_IN(PC_D_IN), .D_IN(D_IN), .DATA_VALID_IN(DATA_VALID_IN), .WRI_EN(WRI_EN),
    .R_AD(R_AD), .PC_R_AD(PC_R_AD), .DE_ADD3(DE_ADD3), .RD_EN(RD_EN), .PC_data(PC_data),
    .DRAM16_data(DRAM16_data), .WR_CMT(WR_CMT), .RD_CMT(RD_CMT)
  );

  always #5 clk_100m = ~clk_100m;

  task automatic tick();
    @(posedge clk_100m); #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic shift_waddr(input logic [5:0] a);
    for (int i = 5; i >= 0; i--) begin
      ADD_IN = a[i]; ADD_VALID_IN = 1'b1; tick();
    end
    ADD_VALID_IN = 1'b0; ADD_IN = 1'b0;
  endtask

  task automatic shift_wdata(input logic [N-1:0][63:0] d);
    for (int i = 63; i >= 0; i--) begin
      for (int k = 0; k < N; k++) D_IN[k] = d[k][i];
      DATA_VALID_IN = 1'b1; PC_D_IN = 2'b11; tick();
      PC_D_IN = 2'b10; tick();
    end
    DATA_VALID_IN = 1'b0;
  endtask

  task automatic shift_raddr(input logic [N-1:0][7:0] a);
    for (int i = 7; i >= 0; i--) begin
      for (int k = 0; k < N; k++) R_AD[k] = a[k][i];
      PC_R_AD = 2'b11; tick();
      PC_R_AD = 2'b10; tick();
    end
  endtask

  task automatic commit(input string tag);
    WRI_EN = 1'b1; tick();
    chk({tag, "_wr_cmt_hi"}, 128'(WR_CMT), 128'(1'b1));
    WRI_EN = 1'b0; tick();
    chk({tag, "_wr_cmt_lo"}, 128'(WR_CMT), 128'(1'b0));
  endtask

  task automatic do_read(input string tag, input logic de3);
    DE_ADD3 = de3;
    RD_EN = 1'b1; tick();
    chk({tag, "_rd_cmt_hi"}, 128'(RD_CMT), 128'(1'b1));
    RD_EN = 1'b0; tick();
    chk({tag, "_rd_cmt_lo"}, 128'(RD_CMT), 128'(1'b0));
  endtask

  // One PC_data clock pulse; inv selects which edge is active.
  task automatic strobe(input logic inv, input logic sr);
    PC_data = {inv, sr, 1'b1}; tick();
    PC_data = {inv, sr, 1'b0}; tick();
  endtask

  task automatic read_byte(input logic inv, output logic [N-1:0][7:0] b);
    strobe(inv, 1'b0);
    for (int k = 0; k < N; k++) b[k][7] = DRAM16_data[k];
    for (int i = 6; i >= 0; i--) begin
      strobe(inv, 1'b1);
      for (int k = 0; k < N; k++) b[k][i] = DRAM16_data[k];
    end
  endtask

  // Row 5 contents: lane k holds byte k*0x11 repeated, lane 3 is special.
  function automatic logic [N-1:0][7:0] row5_bytes(input logic [7:0] lane3);
    logic [N-1:0][7:0] r;
    for (int k = 0; k < N; k++) r[k] = 8'(k * 17);
    r[3] = lane3;
    return r;
  endfunction

  initial begin
    rst_n = 1'b0; ADD_IN = 0; ADD_VALID_IN = 0; PC_D_IN = 2'b10; D_IN = '0;
    DATA_VALID_IN = 0; WRI_EN = 0; R_AD = '0; PC_R_AD = 2'b10; DE_ADD3 = 0;
    RD_EN = 0; PC_data = 3'b000;
    tick(); tick(); tick();
    chk("rst_dout", 128'(DRAM16_data), 128'(16'h0000));
    chk("rst_wr_cmt", 128'(WR_CMT), 128'(1'b0));
    chk("rst_rd_cmt", 128'(RD_CMT), 128'(1'b0));
    rst_n = 1'b1; tick(); tick();

    // Loopback: row 0 = 0x5555.. on all lanes, read slice 0.
    shift_waddr(6'd0);
    for (int k = 0; k < N; k++) wdat[k] = 64'h5555_5555_5555_5555;
    shift_wdata(wdat);
    commit("loop");
    radr = '0; shift_raddr(radr);
    do_read("loop", 1'b0);
    read_byte(1'b0, got);
    exp_b = {N{8'h55}};
    chk("loop_data", 128'(got), 128'(exp_b));

    // Slice/row select on row 5.
    shift_waddr(6'd5);
    for (int k = 0; k < N; k++) wdat[k] = {8{8'(k * 17)}};
    wdat[3] = 64'h0123_4567_89AB_CDEF;
    shift_wdata(wdat);
    commit("row5");
    radr = {N{8'hC5}}; shift_raddr(radr);
    do_read("s7", 1'b1);
    read_byte(1'b0, got);
    chk("slice7", 128'(got), 128'(row5_bytes(8'h01)));
    radr = {N{8'h05}}; shift_raddr(radr);
    do_read("s0", 1'b0);
    read_byte(1'b0, got);
    chk("slice0", 128'(got), 128'(row5_bytes(8'hEF)));
    radr = {N{8'h45}}; radr[0] = 8'h00; shift_raddr(radr);
    do_read("s5", 1'b1);
    read_byte(1'b0, got);
    exp_b = row5_bytes(8'h45); exp_b[0] = 8'h55;
    chk("slice5_lane0_row0", 128'(got), 128'(exp_b));

    // Clear priority: 10 ones, then clear coincident with a shift strobe.
    shift_waddr(6'd7);
    D_IN = '1; DATA_VALID_IN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      PC_D_IN = 2'b11; tick(); PC_D_IN = 2'b10; tick();
    end
    PC_D_IN = 2'b01; tick(); PC_D_IN = 2'b10; tick();
    DATA_VALID_IN = 1'b0;
    commit("clr");
    radr = {N{8'h07}}; shift_raddr(radr);
    do_read("clr", 1'b0);
    read_byte(1'b0, got);
    chk("clear_prio", 128'(got), 128'(0));

    // Write-first collision on row 2.
    shift_waddr(6'd2);
    wdat = '0; shift_wdata(wdat);
    commit("zero2");
    wdat = '1; shift_wdata(wdat);
    radr = {N{8'h02}}; shift_raddr(radr);
    DE_ADD3 = 1'b0;
    WRI_EN = 1'b1; RD_EN = 1'b1; tick();
    chk("coll_wr_cmt", 128'(WR_CMT), 128'(1'b1));
    chk("coll_rd_cmt", 128'(RD_CMT), 128'(1'b1));
    WRI_EN = 1'b0; RD_EN = 1'b0; tick();
    read_byte(1'b0, got);
    chk("coll_data", 128'(got), 128'({N{8'hFF}}));
    // After 7 shifts of 0xFF the PISO holds 0x80.
    chk("coll_tail", 128'(DRAM16_data), 128'(16'hFFFF));

    // CLK_INV: rises ignored, falls load/shift.
    radr = {N{8'hC5}}; shift_raddr(radr);
    do_read("inv", 1'b1);
    PC_data = 3'b100; tick();
    PC_data = 3'b101; tick();
    chk("inv_rise_ignored", 128'(DRAM16_data), 128'(16'hFFFF));
    PC_data = 3'b100; tick();
    chk("inv_fall_load", 128'(DRAM16_data), 128'(16'hFF00));
    for (int k = 0; k < N; k++) got[k][7] = DRAM16_data[k];
    for (int i = 6; i >= 0; i--) begin
      strobe(1'b1, 1'b1);
      for (int k = 0; k < N; k++) got[k][i] = DRAM16_data[k];
    end
    chk("inv_data", 128'(got), 128'(row5_bytes(8'h01)));
    PC_data = 3'b000; tick();

    // Reset mid-read: load then 3 shifts shows bit 4 of each byte.
    strobe(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) strobe(1'b0, 1'b1);
    chk("mid_bit4", 128'(DRAM16_data), 128'(16'hAAA2));
    rst_n = 1'b0; #1;
    chk("mid_rst_dout", 128'(DRAM16_data), 128'(16'h0000));
    tick();
    WRI_EN = 1'b1;
    tick();
    rst_n = 1'b1; tick(); tick();
    chk("held_strobe_no_edge", 128'(WR_CMT), 128'(1'b0));
    WRI_EN = 1'b0; tick();
    radr = {N{8'hC5}}; shift_raddr(radr);
    do_read("rerd", 1'b1);
    read_byte(1'b0, got);
    chk("mid_reread", 128'(got), 128'(row5_bytes(8'h01)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
